// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings, default sizes.
package mdu_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 32;
    localparam int unsigned MULT_LATENCY_DEF = 4;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DIV_FIX = 2'd3
    } state_e;

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, DATA_WIDTH cycles per divide.
module div_core
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done_c,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH:0]   shifted, trial;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        shifted = {rem_q, quo_q[DATA_WIDTH-1]};
        // No borrow out of the top bit means the divisor fits into the partial remainder.
        trial   = shifted - {1'b0, dvs_q};
        if (abort) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            if (!trial[DATA_WIDTH]) begin
                rem_d = trial[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CW'(DATA_WIDTH);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Final iteration is in progress; quotient/remainder are valid after this edge.
    assign done_c    = busy_q && !abort && (cnt_q == CW'(1));
    assign busy      = busy_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiplier, iterative divider, MTHI/MTLO writes.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned MULT_LATENCY = MULT_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(MULT_LATENCY + 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic                  signed_q, signed_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic [PW-1:0]         a_ext, b_ext, product;
    logic [DATA_WIDTH-1:0] dvd_mag_c, dvs_mag_c, div_quo, div_rem;
    logic                  div_start_c, div_busy, div_done_c, q_neg, r_neg;

    // Operands widened so one multiplier serves both signed and unsigned products.
    assign a_ext   = signed_q ? {{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q} : {{DATA_WIDTH{1'b0}}, a_q};
    assign b_ext   = signed_q ? {{DATA_WIDTH{b_q[DATA_WIDTH-1]}}, b_q} : {{DATA_WIDTH{1'b0}}, b_q};
    assign product = a_ext * b_ext;

    assign dvd_mag_c = ((op == OP_DIV) && a[DATA_WIDTH-1]) ? -a : a;
    assign dvs_mag_c = ((op == OP_DIV) && b[DATA_WIDTH-1]) ? -b : b;
    assign q_neg     = signed_q && (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1]);
    assign r_neg     = signed_q && a_q[DATA_WIDTH-1];

    div_core #(.DATA_WIDTH(DATA_WIDTH)) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_c),
        .abort     (flush),
        .dividend  (dvd_mag_c),
        .divisor   (dvs_mag_c),
        .busy      (div_busy),
        .done_c    (div_done_c),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        signed_d    = signed_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        dbz_d       = 1'b0;
        div_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            a_d      = a;
                            b_d      = b;
                            signed_d = (op == OP_MULT);
                            cnt_d    = CW'(MULT_LATENCY - 1);
                            state_d  = ST_MUL_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b == '0) begin
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                a_d         = a;
                                b_d         = b;
                                signed_d    = (op == OP_DIV);
                                div_start_c = 1'b1;
                                state_d     = ST_DIV_RUN;
                            end
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_MUL_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = product;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DIV_RUN: begin
                if (flush || !div_busy) begin
                    state_d = ST_IDLE;
                end else if (div_done_c) begin
                    state_d = ST_DIV_FIX;
                end
            end
            ST_DIV_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    lo_d    = q_neg ? -div_quo : div_quo;
                    hi_d    = r_neg ? -div_rem : div_rem;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and HI/LO register width.
REQ-002 Parameter MULT_LATENCY, default 4: cycles from accepted multiply to HI/LO update; legal range 1..8.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request; sampled only when busy=0.
REQ-006 Port op, input, 3: operation select, with encodings MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; values 6 and 7 are no-ops.
REQ-007 Port a, input, DATA_WIDTH: rs operand, which is also the source for MTHI and MTLO.
REQ-008 Port b, input, DATA_WIDTH: rt operand.
REQ-009 Port flush, input, 1: abort the in-flight operation.
REQ-010 Port busy, output, 1: multi-cycle operation in progress; drives the pipeline stall.
REQ-011 Port done, output, 1: one-cycle pulse when HI/LO have just been updated by a MULT, MULTU, DIV or DIVU.
REQ-012 Port div_by_zero, output, 1: valid with done; set when the divisor was 0.
REQ-013 Port hi, output, DATA_WIDTH: HI register.
REQ-014 Port lo, output, DATA_WIDTH: LO register.

Function
REQ-015 States SHALL be IDLE, MUL_RUN, DIV_RUN and DIV_FIX.
REQ-016 In IDLE, start with a multiply op SHALL latch a and b, enter MUL_RUN, and raise busy from the next cycle.
REQ-017 In IDLE, start with a divide op SHALL latch a and b and enter DIV_RUN.
REQ-018 After operands are latched, a and b SHALL be don't-care.
REQ-019 A multiply SHALL update {hi,lo} with the full 2*DATA_WIDTH product exactly MULT_LATENCY edges after the start edge.
REQ-020 At that same edge the unit SHALL clear busy, pulse done, and return to IDLE.
REQ-021 MULT SHALL form a signed product; MULTU SHALL form an unsigned product.
REQ-022 DIV_RUN SHALL perform DATA_WIDTH radix-2 restoring iterations on the operand magnitudes.
REQ-023 DIV_FIX SHALL then apply sign correction in one cycle.
REQ-024 A divide SHALL therefore update HI/LO DATA_WIDTH+1 edges after the start edge, with busy clearing and done pulsing at that edge.
REQ-025 Divide results SHALL be lo=quotient and hi=remainder.
REQ-026 Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-027 The signed overflow case -2^(DATA_WIDTH-1) / -1 SHALL yield lo=-2^(DATA_WIDTH-1) and hi=0.
REQ-028 A divide with b=0 SHALL skip DIV_RUN, leave hi and lo unchanged, and assert done and div_by_zero one edge after start; busy SHALL stay 0.
REQ-029 div_by_zero SHALL be 0 on every done pulse other than a divide by zero.
REQ-030 MTHI and MTLO SHALL write hi or lo from a at the next edge, without asserting busy or done.
REQ-031 start asserted while busy=1 SHALL be ignored.
REQ-032 flush SHALL return the unit to IDLE at the next edge with busy=0, no done pulse, and hi and lo unchanged.
REQ-033 flush and start in the same cycle SHALL cause start to be ignored.
REQ-034 hi and lo SHALL hold their previous values throughout a running operation, with no partial results visible.

Reset
REQ-035 On reset=1 at a clock edge, state SHALL become IDLE, and hi, lo, busy, done and div_by_zero SHALL all become 0.
REQ-036 Reset SHALL take priority over start and flush.
REQ-037 Reset mid-operation SHALL discard the operation.

Structure
REQ-038 A shared package mdu_pkg SHALL hold the op encodings, the state encoding, and the default values of DATA_WIDTH and MULT_LATENCY.
REQ-039 The iterative divider SHALL be the sub-module div_core: unsigned, DATA_WIDTH-parameterised, with start/busy/done handshake and quotient/remainder outputs.
REQ-040 The multiply path SHALL be a latency counter in mult_div_unit.

Verification (DATA_WIDTH=32, MULT_LATENCY=4)
REQ-041 MULT with a=0xFFFFFFFD and b=7 -> at start+4: hi=0xFFFFFFFF, lo=0xFFFFFFEB; done is high for exactly 1 cycle; busy is high for 4 cycles.
REQ-042 MULTU with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-043 DIVU 100/7 -> at start+33: lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-044 DIV 5/0 -> at start+1: done=1 and div_by_zero=1; busy stays 0; hi and lo are unchanged.
REQ-045 MTHI with a=0x1234 -> hi=0x1234 next cycle with busy=0. A second start at start+5 of a running DIV is ignored.
REQ-046 flush at start+10 of a DIVU -> busy=0 next cycle, no done, hi/lo unchanged. Reset at start+10 of a DIV -> all outputs 0 next cycle.
